// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per clock, signed or
// unsigned operands, registered quotient/remainder/flags, valid/ready on both sides.
module seq_divider #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Quo,
   output logic [WIDTH-1:0] Rem,
   output logic             Dbz,
   output logic             Ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      neg_if = en ? (~v + WIDTH'(1)) : v;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             qneg_q, rneg_q, ovf_pend_q;
   logic [WIDTH-1:0] quo_q, rem_q;
   logic             dbz_q, ovf_q;

   logic             accept_s, sgn_s, dbz_s, last_s, qbit_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s, rem_nxt_s, quo_nxt_s;
   logic [WIDTH:0]   shift_s, diff_s;

   assign accept_s = in_valid && (state_q == IDLE);
   assign sgn_s    = is_signed && SIGNED_EN;
   assign dbz_s    = (B == {WIDTH{1'b0}});
   assign a_mag_s  = neg_if(A, sgn_s && A[WIDTH-1]);
   assign b_mag_s  = neg_if(B, sgn_s && B[WIDTH-1]);
   assign last_s   = (cnt_q == CW'(WIDTH - 1));

   // The held partial remainder is always below the divisor, so its top bit
   // is implicitly zero and only the shifted trial value needs WIDTH+1 bits.
   assign shift_s   = {p_q, dvd_q[WIDTH-1]};
   assign diff_s    = shift_s - {1'b0, dvs_q};
   assign qbit_s    = ~diff_s[WIDTH];
   assign rem_nxt_s = qbit_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
   assign quo_nxt_s = {dvd_q[WIDTH-2:0], qbit_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = dbz_s ? DONE : CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (last_s) begin
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         CALC: begin
            busy = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q        <= {WIDTH{1'b0}};
         dvd_q      <= {WIDTH{1'b0}};
         dvs_q      <= {WIDTH{1'b0}};
         cnt_q      <= {CW{1'b0}};
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         ovf_pend_q <= 1'b0;
         quo_q      <= {WIDTH{1'b0}};
         rem_q      <= {WIDTH{1'b0}};
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s && dbz_s) begin
                  quo_q <= {WIDTH{1'b1}};
                  rem_q <= A;
                  dbz_q <= 1'b1;
                  ovf_q <= 1'b0;
               end else if (accept_s) begin
                  p_q        <= {WIDTH{1'b0}};
                  dvd_q      <= a_mag_s;
                  dvs_q      <= b_mag_s;
                  cnt_q      <= {CW{1'b0}};
                  qneg_q     <= sgn_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                  rneg_q     <= sgn_s && A[WIDTH-1];
                  ovf_pend_q <= sgn_s && (A == {1'b1, {(WIDTH-1){1'b0}}})
                                      && (B == {WIDTH{1'b1}});
               end
            end
            CALC: begin
               p_q   <= rem_nxt_s;
               dvd_q <= quo_nxt_s;
               cnt_q <= cnt_q + CW'(1);
               if (last_s) begin
                  // Most-negative / -1 wraps naturally to 2^(WIDTH-1), remainder 0.
                  quo_q <= neg_if(quo_nxt_s, qneg_q);
                  rem_q <= neg_if(rem_nxt_s, rneg_q);
                  dbz_q <= 1'b0;
                  ovf_q <= ovf_pend_q;
               end
            end
            default: begin
               cnt_q <= cnt_q;
            end
         endcase
      end
   end

   assign Quo = quo_q;
   assign Rem = rem_q;
   assign Dbz = dbz_q;
   assign Ovf = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: scoreboard queue of expected results, checked
// with immediate assertions when the divider presents each result.
module tb_seq_divider;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        d;
      logic        o;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, sgn = 1'b0;
   logic [15:0] a = 16'd0, b = 16'd0;
   logic        out_valid, out_ready = 1'b0, dbz, ovf, busy;
   logic [15:0] quo, rem;

   logic        in_valid1 = 1'b0, in_ready1, sgn1 = 1'b0;
   logic [15:0] a1 = 16'd0, b1 = 16'd0;
   logic        out_valid1, out_ready1 = 1'b0, dbz1, ovf1, busy1;
   logic [15:0] quo1, rem1;

   res_t exp_q[$];
   int   n_asserts = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .is_signed(sgn), .out_valid(out_valid), .out_ready(out_ready),
      .Quo(quo), .Rem(rem), .Dbz(dbz), .Ovf(ovf), .busy(busy));

   seq_divider #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut_uns (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .A(a1), .B(b1), .is_signed(sgn1), .out_valid(out_valid1), .out_ready(out_ready1),
      .Quo(quo1), .Rem(rem1), .Dbz(dbz1), .Ovf(ovf1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] q, input logic [15:0] r, input logic d, input logic o);
      res_t e;
      e.q = q; e.r = r; e.d = d; e.o = o;
      exp_q.push_back(e);
   endtask

   // Drive one operand set through the accept edge, then scramble the inputs.
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic s);
      a = av; b = bv; sgn = s; in_valid = 1'b1;
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sgn = ~s;
   endtask

   task automatic wait_valid(input int exp_lat);
      int n = 0;
      while (!out_valid && n < 64) begin
         tick();
         n++;
      end
      if (exp_lat >= 0) chk("latency", n, exp_lat);
      else chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic check_pop();
      res_t e;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("Quo", quo, e.q);
         chk("Rem", rem, e.r);
         chk("Dbz", {31'd0, dbz}, {31'd0, e.d});
         chk("Ovf", {31'd0, ovf}, {31'd0, e.o});
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic s,
                         input logic [15:0] q, input logic [15:0] r, input logic o);
      push(q, r, 1'b0, o);
      send(av, bv, s);
      wait_valid(16);
      check_pop();
      handshake();
   endtask

   task automatic run_uns(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] q, input logic [15:0] r);
      int n = 0;
      a1 = av; b1 = bv; sgn1 = 1'b1; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      while (!out_valid1 && n < 64) begin
         tick();
         n++;
      end
      chk("uns_latency", n, 16);
      chk("uns_Quo", quo1, q);
      chk("uns_Rem", rem1, r);
      chk("uns_Ovf", {31'd0, ovf1}, 32'd0);
      chk("uns_Dbz", {31'd0, dbz1}, 32'd0);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb, eq, er;
      logic signed [15:0] sa, sb;

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_Quo", quo, 32'd0);
      chk("rst_Rem", rem, 32'd0);
      chk("rst_flags", {30'd0, dbz, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic unsigned and signed results
      run_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0);
      run_op(16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
      run_op(16'hFFF9, 16'd2, 1'b0, 16'h7FFC, 16'd1, 1'b0);
      run_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0, 1'b1);
      run_op(16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0);
      run_op(16'd5, 16'd9, 1'b0, 16'd0, 16'd5, 1'b0);

      // Divide by zero
      push(16'hFFFF, 16'h1234, 1'b1, 1'b0);
      send(16'h1234, 16'd0, 1'b0);
      chk("dbz_busy_after_accept", {31'd0, busy}, 32'd1);
      tick();
      chk("dbz_out_valid_edge1", {31'd0, out_valid}, 32'd1);
      chk("dbz_busy_edge1", {31'd0, busy}, 32'd1);
      wait_valid(-1);
      check_pop();
      handshake();
      chk("dbz_busy_after_hs", {31'd0, busy}, 32'd0);

      // Backpressure with a second request waiting
      push(16'd66, 16'd2, 1'b0, 1'b0);
      send(16'd200, 16'd3, 1'b0);
      wait_valid(16);
      check_pop();
      a = 16'd50; b = 16'd5; sgn = 1'b0; in_valid = 1'b1;
      push(16'd10, 16'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_Quo", quo, 16'd66);
         chk("bp_Rem", rem, 16'd2);
         chk("bp_flags", {30'd0, dbz, ovf}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      handshake();
      chk("bp_not_accepted_at_hs", {31'd0, busy}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bp_accepted_after_hs", {31'd0, busy}, 32'd1);
      wait_valid(16);
      check_pop();
      handshake();

      // Reset in the middle of a calculation
      send(16'hBEEF, 16'd3, 1'b0);
      repeat (8) tick();
      chk("mid_calc_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_Quo", quo, 32'd0);
      chk("arst_Rem", rem, 32'd0);
      chk("arst_flags", {30'd0, dbz, ovf}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      run_op(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0);

      // Randomised operands against the language's own division
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom_range(1, 65535));
         if (i[1]) rb = 16'($urandom_range(1, 40));
         if (ra == 16'h8000 && rb == 16'hFFFF) rb = 16'd3;
         if (i[0]) begin
            sa = ra; sb = rb;
            eq = 16'(sa / sb);
            er = 16'(sa % sb);
         end else begin
            eq = ra / rb;
            er = ra % rb;
         end
         run_op(ra, rb, i[0], eq, er, 1'b0);
      end

      // Instance with signed mode disabled ignores is_signed
      run_uns(16'h8000, 16'hFFFF, 16'd0, 16'h8000);
      run_uns(16'hFFF9, 16'd2, 16'h7FFC, 16'd1);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
